sync_fifo: RTL
==============

Name: sync_fifo

Overview:
Single-clock parametrised FIFO, the next generation of the team's FIFO storage block.
- Adds over the bare memory: pointer and flag management, occupancy count, programmable almost-full and almost-empty thresholds, a selectable read mode (registered or first-word fall-through), synchronous clear, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WD, 8, data width in bits.
- ADDR_WD, 4, address width; DEPTH = 2^ADDR_WD entries.
- AFULL_TH, 12, walmost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 2, ralmost_empty asserted when count <= AEMPTY_TH.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word fall-through.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sclr  input  1  synchronous clear.
- winc  input  1  write request.
- wdata  input  DATA_WD  write data.
- wfull  output  1  FIFO full.
- walmost_full  output  1  count >= AFULL_TH.
- rinc  input  1  read request.
- rdata  output  DATA_WD  read data.
- rvalid  output  1  rdata valid.
- rempty  output  1  FIFO empty.
- ralmost_empty  output  1  count <= AEMPTY_TH.
- count  output  ADDR_WD+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: wptr = rptr = 0, count 0, rempty 1, ralmost_empty 1, wfull 0, walmost_full 0, rvalid 0, rdata 0, overflow 0, underflow 0.
- Pointers: wptr and rptr are ADDR_WD+1 bits and wrap modulo 2^(ADDR_WD+1).
  - Memory address = pointer[ADDR_WD-1:0].
  - rempty = (wptr == rptr).
  - wfull = (MSBs differ AND low bits equal).
  - count = wptr - rptr, width ADDR_WD+1.
- Flag timing: all flags and count derive from registered state only. No combinational path from winc/rinc to any flag.
- Accepted write: winc && !wfull. Memory written at the edge; wptr increments.
- Accepted read: rinc && !rempty. rptr increments.
- Simultaneous events:
  - Full: read accepted, write rejected. The count drops by 1.
  - Empty: write accepted, read rejected. The count rises by 1; underflow sets.
  - Neither full nor empty: both accepted; count unchanged.
- overflow sets on winc && wfull; underflow sets on rinc && rempty. Both hold until rst or sclr.
- FWFT=0 (registered read):
  - rdata loads mem[rptr] on the edge of an accepted read; rvalid = 1 for the following cycle only.
  - rdata holds its value otherwise.
  - Read latency 1 cycle.
- FWFT=1:
  - rdata = mem[rptr] combinationally; rvalid = !rempty.
  - A rinc accepted while rvalid=1 pops the displayed word.
  - A write into an empty FIFO becomes visible (rvalid=1) the cycle after the write edge.
- Wrap-around: after 2^(ADDR_WD+1) operations, pointers return to 0 with no flag glitch.
- sclr:
  - Takes priority over winc/rinc in the same cycle.
  - Returns pointers, count, flags, rvalid and sticky bits to reset values.
  - rdata and memory contents are not cleared.
- Reset mid-operation: all state returns to reset values immediately. Memory contents are undefined afterwards and never exposed, because rempty=1.
- Legal parameters: 0 <= AEMPTY_TH < AFULL_TH <= DEPTH. Violations stop elaboration with an error.

Decomposition:
- Shared package/header holds:
  - DEPTH and PTR_WD = ADDR_WD+1 derivation.
  - Read-mode constants FWFT_OFF=0 and FWFT_ON=1.
  - Threshold legality checks.
- One sub-module, sync_fifo_ram:
  - Single-clock dual-port array with a write enable.
  - Combinational read port, registered in the parent only when FWFT=0.
- Pointer/flag logic stays in sync_fifo.

Test Plan:
(Default parameters: DATA_WD 8, ADDR_WD 4, DEPTH 16.)
- Reset then idle: rst pulse -> rempty=1, ralmost_empty=1, wfull=0, count=0, rvalid=0, rdata=0.
- Fill and drain:
  - Write 0x00..0x0F -> walmost_full rises when count reaches 12; wfull=1 at count=16.
  - 17th write -> overflow=1, count stays 16.
  - Then read 16 -> data 0x00..0x0F in order (FWFT=0: each rdata one cycle after rinc with rvalid), rempty=1 after the last read.
- Simultaneous at boundaries:
  - At full, winc&rinc -> count 15, wfull=0, rejected word absent from later reads.
  - At empty, winc&rinc -> count 1, underflow=1, the next read returns the written word.
- Wrap-around: 40 writes interleaved with reads, occupancy kept at 5 -> data order preserved across pointer wrap; count=5 throughout the steady state.
- FWFT=1: write 0xA5 into empty FIFO -> next cycle rvalid=1, rdata=0xA5 with no rinc; rinc -> rempty=1, rvalid=0 next cycle.
- Clear and mid-op reset:
  - sclr with count=7 and winc=1 -> count=0, rempty=1, overflow/underflow=0, write discarded.
  - rst asserted mid-burst -> outputs at reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo block.
// Holds the geometry derivations (DEPTH, PTR_WD), the read-mode constants and
// the parameter legality checks used by sync_fifo and sync_fifo_ram.
package sync_fifo_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  // Number of storage entries for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned addr_wd);
    return 32'd1 << addr_wd;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned fifo_ptr_wd(input int unsigned addr_wd);
    return addr_wd + 32'd1;
  endfunction

  // 0 <= aempty_th < afull_th <= depth (the lower bound holds by type).
  function automatic bit thresholds_legal(input int unsigned aempty_th,
                                          input int unsigned afull_th,
                                          input int unsigned depth);
    return (aempty_th < afull_th) && (afull_th <= depth);
  endfunction

  function automatic bit fwft_legal(input int unsigned fwft);
    return (fwft == FWFT_OFF) || (fwft == FWFT_ON);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo.
// Single-clock dual-port memory: one synchronous write port, one combinational
// read port. No reset; contents are only ever exposed through valid pointers.
//   clk    : clock, writes on rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned ADDR_WD = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [DATA_WD-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WD);

  logic [DATA_WD-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty
// thresholds, registered or first-word fall-through read, synchronous clear and
// sticky overflow/underflow flags. All flags derive from registered state only.
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   sclr          : synchronous clear, overrides winc/rinc
//   winc, wdata   : write request and data
//   wfull         : FIFO full
//   walmost_full  : count >= AFULL_TH
//   rinc          : read request
//   rdata, rvalid : read data and its qualifier
//   rempty        : FIFO empty
//   ralmost_empty : count <= AEMPTY_TH
//   count         : occupancy 0..DEPTH
//   overflow      : sticky, write attempted while full
//   underflow     : sticky, read attempted while empty
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WD   = 8,
  parameter int unsigned ADDR_WD   = 4,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = FWFT_OFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclr,
  input  logic               winc,
  input  logic [DATA_WD-1:0] wdata,
  output logic               wfull,
  output logic               walmost_full,
  input  logic               rinc,
  output logic [DATA_WD-1:0] rdata,
  output logic               rvalid,
  output logic               rempty,
  output logic               ralmost_empty,
  output logic [ADDR_WD:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned DEPTH  = fifo_depth(ADDR_WD);
  localparam int unsigned PTR_WD = fifo_ptr_wd(ADDR_WD);

  localparam logic [PTR_WD-1:0] AFULL_CNT  = PTR_WD'(AFULL_TH);
  localparam logic [PTR_WD-1:0] AEMPTY_CNT = PTR_WD'(AEMPTY_TH);

  if (!thresholds_legal(AEMPTY_TH, AFULL_TH, DEPTH)) begin : g_bad_thresholds
    $error("sync_fifo: need 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end
  if (!fwft_legal(FWFT)) begin : g_bad_fwft
    $error("sync_fifo: FWFT must be 0 or 1");
  end

  logic [PTR_WD-1:0]  wptr_q, wptr_d;
  logic [PTR_WD-1:0]  rptr_q, rptr_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               wr_en, rd_en;
  logic [DATA_WD-1:0] ram_rdata;

  // Flags from registered pointers only.
  assign count         = wptr_q - rptr_q;
  assign rempty        = (wptr_q == rptr_q);
  assign wfull         = (wptr_q[PTR_WD-1] != rptr_q[PTR_WD-1]) &&
                         (wptr_q[ADDR_WD-1:0] == rptr_q[ADDR_WD-1:0]);
  assign walmost_full  = (count >= AFULL_CNT);
  assign ralmost_empty = (count <= AEMPTY_CNT);
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  // sclr suppresses both transfers, so memory is untouched by a cleared write.
  assign wr_en = winc && !wfull  && !sclr;
  assign rd_en = rinc && !rempty && !sclr;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q  | (winc && wfull);
    underflow_d = underflow_q | (rinc && rempty);
    if (sclr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PTR_WD'(1);
      if (rd_en) rptr_d = rptr_q + PTR_WD'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WD (DATA_WD),
    .ADDR_WD (ADDR_WD)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q[ADDR_WD-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ADDR_WD-1:0]),
    .rdata (ram_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word is shown directly; an accepted read pops it.
    assign rdata  = ram_rdata;
    assign rvalid = !rempty;
  end else begin : g_registered
    logic [DATA_WD-1:0] rdata_q;
    logic               rvalid_q;

    // rdata holds between reads and survives sclr; rvalid is a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_en;
        if (rd_en) rdata_q <= ram_rdata;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule
